// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds the frame FSM encoding, the prefix byte values and a parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    localparam logic [7:0] BYTE_BREAK = 8'hF0;
    localparam logic [7:0] BYTE_EXT0  = 8'hE0;
    localparam logic [7:0] BYTE_EXT1  = 8'hE1;

    // 1 when the 8 data bits plus the parity bit carry odd parity
    function automatic logic odd_ok(
        input logic [7:0] d,
        input logic       p
    );
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_receiver_if.sv
// Decoded-key output bundle of the PS/2 receiver.
// Ports: code[7:0], strobe, pressed (0=make), extended, error.
interface ps2_receiver_if;

    logic [7:0] code;
    logic       strobe;
    logic       pressed;
    logic       extended;
    logic       error;

    modport master (
        output code,
        output strobe,
        output pressed,
        output extended,
        output error
    );

    modport slave (
        input code,
        input strobe,
        input pressed,
        input extended,
        input error
    );

endinterface

// File: rtl/ps2_filter.sv
// Two-flop synchronizer plus consecutive-sample filter for ps2_clk.
// Ports: clock, reset, ce, raw_i (async line), fall_o (filtered 1->0 pulse).
module ps2_filter #(
    parameter int FILTER = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic ce,
    input  logic raw_i,
    output logic fall_o
);

    localparam int FW = $clog2(FILTER + 1);

    logic [1:0]    sync_q;
    logic          lvl_q;
    logic          lvl_d;
    logic [FW-1:0] cnt_q;
    logic [FW-1:0] cnt_d;

    // Level flips only after FILTER back-to-back ce samples disagree;
    // any agreeing sample restarts the run.
    always_comb begin
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        fall_o = 1'b0;
        if (ce) begin
            if (sync_q[1] == lvl_q) begin
                cnt_d = '0;
            end else if (cnt_q == FW'(FILTER - 1)) begin
                cnt_d  = '0;
                lvl_d  = sync_q[1];
                fall_o = lvl_q;
            end else begin
                cnt_d = cnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b11;
            lvl_q  <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: frames 11-bit packets and decodes F0/E0/E1 prefixes.
// Ports: clock, reset, ce, ps2_clk, ps2_data, rx (code/strobe/pressed/extended/error).
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           ce,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_receiver_if.master rx
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic          fall;
    logic [1:0]    dsync_q;
    logic          data_s;

    state_e        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic [7:0]    code_q, code_d;
    logic          pressed_q, pressed_d;
    logic          extended_q, extended_d;
    logic          strobe_q, strobe_d;
    logic          error_q, error_d;

    ps2_filter #(
        .FILTER (FILTER)
    ) u_clk_filter (
        .clock  (clock),
        .reset  (reset),
        .ce     (ce),
        .raw_i  (ps2_clk),
        .fall_o (fall)
    );

    assign data_s = dsync_q[1];

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        code_d     = code_q;
        pressed_d  = pressed_q;
        extended_d = extended_q;
        strobe_d   = 1'b0;
        error_d    = 1'b0;

        if (state_q == ST_IDLE || fall) begin
            tmo_d = '0;
        end else if (ce) begin
            tmo_d = tmo_q + TW'(1);
        end

        if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end else begin
                        error_d = 1'b1;
                        brk_d   = 1'b0;
                        ext_d   = 1'b0;
                    end
                end
                ST_DATA: begin
                    shift_d  = {data_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = data_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (data_s && odd_ok(shift_q, par_q)) begin
                        if (shift_q == BYTE_BREAK) begin
                            brk_d = 1'b1;
                        end else if (shift_q == BYTE_EXT0 ||
                                     shift_q == BYTE_EXT1) begin
                            ext_d = 1'b1;
                        end else begin
                            code_d     = shift_q;
                            pressed_d  = brk_q;
                            extended_d = ext_q;
                            strobe_d   = 1'b1;
                            brk_d      = 1'b0;
                            ext_d      = 1'b0;
                        end
                    end else begin
                        error_d = 1'b1;
                        brk_d   = 1'b0;
                        ext_d   = 1'b0;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE && ce &&
                     tmo_q == TW'(TIMEOUT - 1)) begin
            // Line went quiet mid-frame: drop it
            state_d = ST_IDLE;
            tmo_d   = '0;
            error_d = 1'b1;
            brk_d   = 1'b0;
            ext_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dsync_q    <= 2'b11;
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            code_q     <= 8'h00;
            pressed_q  <= 1'b1;
            extended_q <= 1'b0;
            strobe_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            dsync_q    <= {dsync_q[0], ps2_data};
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            code_q     <= code_d;
            pressed_q  <= pressed_d;
            extended_q <= extended_d;
            strobe_q   <= strobe_d;
            error_q    <= error_d;
        end
    end

    assign rx.code     = code_q;
    assign rx.strobe   = strobe_q;
    assign rx.pressed  = pressed_q;
    assign rx.extended = extended_q;
    assign rx.error    = error_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: frame table plus latency, glitch,
// timeout and mid-frame reset sequences.
module tb_ps2_receiver;
    import ps2_pkg::*;

    localparam int FILTER  = 4;
    localparam int TIMEOUT = 64;
    localparam int HALF    = 12;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    ps2_receiver_if rx_if ();

    ps2_receiver #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx       (rx_if)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0;
    int n_err = 0;
    int n_both = 0;

    always @(negedge clock) begin
        if (rx_if.strobe) n_strobe++;
        if (rx_if.error) n_err++;
        if (rx_if.strobe && rx_if.error) n_both++;
    end

    typedef struct {
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       badpar;
        int         exp_strobe;
        int         exp_error;
        logic [7:0] exp_code;
        logic       exp_pressed;
        logic       exp_ext;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic badpar,
                              input int glitch_bit, input logic chk_lat,
                              input int nbits);
        logic [10:0] bits;
        int s0;
        bits = {1'b1, (~^b) ^ badpar, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            ps2_data = bits[i];
            if (i == glitch_bit) begin
                wait_cyc(4);
                ps2_clk = 1'b0;
                wait_cyc(FILTER - 1);
                ps2_clk = 1'b1;
                wait_cyc(HALF - 4 - (FILTER - 1));
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b0;
            if (chk_lat && i == 10) begin
                s0 = n_strobe;
                wait_cyc(FILTER + 1);
                check("lat_early", n_strobe - s0, 0);
                wait_cyc(1);
                check("lat_exact", 32'(rx_if.strobe), 1);
                wait_cyc(HALF - FILTER - 2);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b1;
        end
    endtask

    initial begin
        int s0;
        int e0;
        logic [7:0] b;

        vecs[0]  = '{1, 8'h1C, 8'h00, 8'h00, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[1]  = '{2, 8'hF0, 8'h1C, 8'h00, 1'b0, 1, 0, 8'h1C, 1'b1, 1'b0};
        vecs[2]  = '{3, 8'hE0, 8'hF0, 8'h11, 1'b0, 1, 0, 8'h11, 1'b1, 1'b1};
        vecs[3]  = '{3, 8'hF0, 8'hE0, 8'h75, 1'b0, 1, 0, 8'h75, 1'b1, 1'b1};
        vecs[4]  = '{2, 8'hE0, 8'h74, 8'h00, 1'b0, 1, 0, 8'h74, 1'b0, 1'b1};
        vecs[5]  = '{2, 8'hE1, 8'h14, 8'h00, 1'b0, 1, 0, 8'h14, 1'b0, 1'b1};
        vecs[6]  = '{1, 8'h29, 8'h00, 8'h00, 1'b1, 0, 1, 8'h14, 1'b0, 1'b1};
        vecs[7]  = '{1, 8'h29, 8'h00, 8'h00, 1'b0, 1, 0, 8'h29, 1'b0, 1'b0};
        vecs[8]  = '{2, 8'hF0, 8'h29, 8'h00, 1'b1, 0, 1, 8'h29, 1'b0, 1'b0};
        vecs[9]  = '{1, 8'h5A, 8'h00, 8'h00, 1'b0, 1, 0, 8'h5A, 1'b0, 1'b0};
        vecs[10] = '{1, 8'hAA, 8'h00, 8'h00, 1'b0, 1, 0, 8'hAA, 1'b0, 1'b0};
        vecs[11] = '{1, 8'h00, 8'h00, 8'h00, 1'b0, 1, 0, 8'h00, 1'b0, 1'b0};
        vecs[12] = '{2, 8'hF0, 8'hFA, 8'h00, 1'b0, 1, 0, 8'hFA, 1'b1, 1'b0};

        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(2);
        check("rst_code", 32'(rx_if.code), 32'h00);
        check("rst_pressed", 32'(rx_if.pressed), 1);
        check("rst_ext", 32'(rx_if.extended), 0);
        check("rst_strobe", 32'(rx_if.strobe), 0);
        check("rst_error", 32'(rx_if.error), 0);
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

        for (int v = 0; v < 13; v++) begin
            s0 = n_strobe;
            e0 = n_err;
            for (int k = 0; k < vecs[v].n; k++) begin
                b = (k == 0) ? vecs[v].b0 :
                    (k == 1) ? vecs[v].b1 : vecs[v].b2;
                send_frame(b, vecs[v].badpar && (k == vecs[v].n - 1),
                           -1, 1'b0, 11);
            end
            wait_cyc(20);
            check($sformatf("v%0d_strobes", v), n_strobe - s0,
                  vecs[v].exp_strobe);
            check($sformatf("v%0d_errors", v), n_err - e0,
                  vecs[v].exp_error);
            check($sformatf("v%0d_code", v), 32'(rx_if.code),
                  32'(vecs[v].exp_code));
            check($sformatf("v%0d_pressed", v), 32'(rx_if.pressed),
                  32'(vecs[v].exp_pressed));
            check($sformatf("v%0d_ext", v), 32'(rx_if.extended),
                  32'(vecs[v].exp_ext));
        end

        // strobe exactly one clock after the stop bit is taken
        s0 = n_strobe;
        send_frame(8'h1C, 1'b0, -1, 1'b1, 11);
        wait_cyc(20);
        check("lat_count", n_strobe - s0, 1);

        // short glitch while idle with data high
        s0 = n_strobe;
        e0 = n_err;
        @(negedge clock);
        ps2_data = 1'b1;
        ps2_clk = 1'b0;
        wait_cyc(FILTER - 1);
        ps2_clk = 1'b1;
        wait_cyc(20);
        check("glitch_idle_err", n_err - e0, 0);
        check("glitch_idle_strb", n_strobe - s0, 0);
        check("glitch_idle_state", 32'(dut.state_q), 32'(ST_IDLE));

        // short glitch inside a frame
        s0 = n_strobe;
        e0 = n_err;
        send_frame(8'h33, 1'b0, 3, 1'b0, 11);
        wait_cyc(20);
        check("glitch_frm_strb", n_strobe - s0, 1);
        check("glitch_frm_err", n_err - e0, 0);
        check("glitch_frm_code", 32'(rx_if.code), 32'h33);

        // stall after 4 data bits
        s0 = n_strobe;
        e0 = n_err;
        send_frame(8'h5A, 1'b0, -1, 1'b0, 5);
        wait_cyc(30);
        check("tmo_early", n_err - e0, 0);
        wait_cyc(TIMEOUT);
        check("tmo_err", n_err - e0, 1);
        check("tmo_strb", n_strobe - s0, 0);
        check("tmo_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("tmo_code", 32'(rx_if.code), 32'h33);
        send_frame(8'h5A, 1'b0, -1, 1'b0, 11);
        wait_cyc(20);
        check("tmo_next_strb", n_strobe - s0, 1);
        check("tmo_next_code", 32'(rx_if.code), 32'h5A);

        // reset in the middle of a frame
        s0 = n_strobe;
        e0 = n_err;
        send_frame(8'h44, 1'b0, -1, 1'b0, 5);
        @(negedge clock);
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(2 * TIMEOUT);
        check("mrst_strb", n_strobe - s0, 0);
        check("mrst_err", n_err - e0, 0);
        check("mrst_code", 32'(rx_if.code), 32'h00);
        check("mrst_pressed", 32'(rx_if.pressed), 1);
        check("mrst_state", 32'(dut.state_q), 32'(ST_IDLE));

        check("strobe_error_overlap", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
